// File: rtl/red_pitaya_fads_logger.sv
// FADS droplet logger.
// Watches the sorter's per-droplet result registers. Each time a new non-zero
// droplet id appears, it captures one record (id, width, class/intensity) into
// a FIFO. Software drains the records over the system bus.
//
// Ports:
//   adc_clk_i, adc_rstn_i      clock, asynchronous active-low reset
//   droplet_*_i                per-droplet results from the sorter
//   sys_addr/wdata/sel/wen/ren bus request (sys_sel ignored, full-word only)
//   sys_rdata/err/ack          bus response, registered, one-cycle ack
//
// Register map (sys_addr[19:0]):
//   0x00 STATUS  {overflow, full, empty, 13'b0, count[15:0]}
//   0x04 CTRL    bit0 enable (rw, resets to 1), bit1 clear (write-1 pulse)
//   0x08 DROPPED saturating count of records lost to a full FIFO
//   0x10/0x14/0x18 HEAD_W0/W1/W2; reading W2 pops the head record
module red_pitaya_fads_logger #(
  parameter int unsigned DEPTH_LOG = 10,
  parameter int unsigned DWT       = 14,
  parameter int unsigned MEM       = 32
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rstn_i,
  input  logic [MEM-1:0]        droplet_id_i,
  input  logic signed [DWT-1:0] droplet_intensity_i,
  input  logic [MEM-1:0]        droplet_width_i,
  input  logic [7:0]            droplet_class_i,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic [3:0]            sys_sel,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG;

  localparam logic [19:0] AddrStatus  = 20'h00;
  localparam logic [19:0] AddrCtrl    = 20'h04;
  localparam logic [19:0] AddrDropped = 20'h08;
  localparam logic [19:0] AddrHeadW0  = 20'h10;
  localparam logic [19:0] AddrHeadW1  = 20'h14;
  localparam logic [19:0] AddrHeadW2  = 20'h18;

  localparam logic [DEPTH_LOG:0] CountFull = {1'b1, {DEPTH_LOG{1'b0}}};

  // Record storage: deliberately not reset.
  logic [31:0] mem_w0 [Depth];
  logic [31:0] mem_w1 [Depth];
  logic [31:0] mem_w2 [Depth];

  logic [MEM-1:0]     last_id_q;
  logic [DEPTH_LOG-1:0] wp_q, rp_q;
  logic [DEPTH_LOG:0] count_q, count_d;
  logic [31:0]        dropped_q;
  logic               overflow_q;
  logic               enable_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q;

  logic [19:0] addr;
  logic        empty, full;
  logic        push, pop, push_ok, ctrl_wr, clear;
  logic [31:0] rec_w2;

  logic unused_bits;
  assign unused_bits = ^{sys_sel, sys_wdata[31:2], sys_addr[31:20]};

  assign addr  = sys_addr[19:0];
  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

  assign push    = enable_q && (droplet_id_i != last_id_q) && (droplet_id_i != '0);
  assign pop     = sys_ren && (addr == AddrHeadW2) && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ctrl_wr = sys_wen && (addr == AddrCtrl);
  assign clear   = ctrl_wr && sys_wdata[1];

  always_comb begin
    rec_w2                = '0;
    rec_w2[31:24]         = droplet_class_i;
    rec_w2[DWT-1:0]       = droplet_intensity_i;
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (sys_ren) begin
      case (addr)
        AddrStatus:  rdata_d = {overflow_q, full, empty, 13'b0, 16'(count_q)};
        AddrCtrl:    rdata_d = {31'b0, enable_q};
        AddrDropped: rdata_d = dropped_q;
        AddrHeadW0:  rdata_d = empty ? '0 : mem_w0[rp_q];
        AddrHeadW1:  rdata_d = empty ? '0 : mem_w1[rp_q];
        AddrHeadW2:  rdata_d = empty ? '0 : mem_w2[rp_q];
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (push_ok && !clear) begin
      mem_w0[wp_q] <= 32'(droplet_id_i);
      mem_w1[wp_q] <= 32'(droplet_width_i);
      mem_w2[wp_q] <= rec_w2;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      last_id_q  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      last_id_q <= droplet_id_i;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      ack_q     <= sys_wen | sys_ren;
      if (ctrl_wr) begin
        enable_q <= sys_wdata[0];
      end
      if (clear) begin
        wp_q       <= '0;
        rp_q       <= '0;
        dropped_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok) begin
          wp_q <= wp_q + 1'b1;
        end
        if (pop) begin
          rp_q <= rp_q + 1'b1;
        end
        if (push && !push_ok) begin
          overflow_q <= 1'b1;
          if (dropped_q != '1) begin
            dropped_q <= dropped_q + 1'b1;
          end
        end
      end
    end
  end

  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_fads_logger.sv
module tb_red_pitaya_fads_logger;

  localparam int DL    = 2;
  localparam int Depth = 4;

  logic               adc_clk_i = 1'b0;
  logic               adc_rstn_i;
  logic [31:0]        droplet_id_i;
  logic signed [13:0] droplet_intensity_i;
  logic [31:0]        droplet_width_i;
  logic [7:0]         droplet_class_i;
  logic [31:0]        sys_addr;
  logic [31:0]        sys_wdata;
  logic [3:0]         sys_sel;
  logic               sys_wen;
  logic               sys_ren;
  logic [31:0]        sys_rdata;
  logic               sys_err;
  logic               sys_ack;

  red_pitaya_fads_logger #(
    .DEPTH_LOG(DL),
    .DWT      (14),
    .MEM      (32)
  ) dut (
    .adc_clk_i          (adc_clk_i),
    .adc_rstn_i         (adc_rstn_i),
    .droplet_id_i       (droplet_id_i),
    .droplet_intensity_i(droplet_intensity_i),
    .droplet_width_i    (droplet_width_i),
    .droplet_class_i    (droplet_class_i),
    .sys_addr           (sys_addr),
    .sys_wdata          (sys_wdata),
    .sys_sel            (sys_sel),
    .sys_wen            (sys_wen),
    .sys_ren            (sys_ren),
    .sys_rdata          (sys_rdata),
    .sys_err            (sys_err),
    .sys_ack            (sys_ack)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: records as a queue, plus scalar control state.
  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } rec_t;

  rec_t        q[$];
  logic        m_en;
  logic        m_ovf;
  logic [31:0] m_dropped;
  logic [31:0] m_last;
  logic [31:0] exp_rdata;
  logic        exp_ack;

  function automatic logic [31:0] m_read(input logic [19:0] a);
    int sz = q.size();
    case (a)
      20'h00:  return {m_ovf, sz == Depth, sz == 0, 13'b0, 16'(sz)};
      20'h04:  return {31'b0, m_en};
      20'h08:  return m_dropped;
      20'h10:  return (sz > 0) ? q[0].w0 : 32'h0;
      20'h14:  return (sz > 0) ? q[0].w1 : 32'h0;
      20'h18:  return (sz > 0) ? q[0].w2 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_en      = 1'b1;
    m_ovf     = 1'b0;
    m_dropped = 32'h0;
    m_last    = 32'h0;
    exp_rdata = 32'h0;
    exp_ack   = 1'b0;
  endtask

  // Advance one clock: model consumes the inputs the DUT sees at this edge.
  task automatic tick();
    logic [19:0] a;
    logic        pop, clr, push, was_full;
    rec_t        r;
    a         = sys_addr[19:0];
    exp_ack   = sys_ren | sys_wen;
    exp_rdata = sys_ren ? m_read(a) : 32'h0;
    pop       = sys_ren && (a == 20'h18) && (q.size() > 0);
    clr       = sys_wen && (a == 20'h04) && sys_wdata[1];
    push      = m_en && (droplet_id_i != m_last) && (droplet_id_i != 0);
    was_full  = (q.size() == Depth);
    r.w0      = droplet_id_i;
    r.w1      = droplet_width_i;
    r.w2      = {droplet_class_i, 10'b0, droplet_intensity_i};
    if (clr) begin
      q.delete();
      m_dropped = 32'h0;
      m_ovf     = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (was_full && !pop) begin
          m_ovf = 1'b1;
          if (m_dropped != 32'hFFFF_FFFF) m_dropped = m_dropped + 1;
        end else begin
          q.push_back(r);
        end
      end
    end
    if (sys_wen && a == 20'h04) m_en = sys_wdata[0];
    m_last = droplet_id_i;
    @(posedge adc_clk_i);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    sys_addr = addr;
    sys_ren  = 1'b1;
    tick();
    sys_ren  = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    sys_addr  = addr;
    sys_wdata = data;
    sys_wen   = 1'b1;
    tick();
    sys_wen   = 1'b0;
  endtask

  task automatic new_drop(input logic [31:0] id);
    droplet_id_i        = id;
    droplet_intensity_i = 14'($urandom);
    droplet_width_i     = $urandom;
    droplet_class_i     = 8'($urandom);
    tick();
  endtask

  task automatic test_reset();
    adc_rstn_i = 1'b0;
    droplet_id_i = 0; droplet_intensity_i = 0; droplet_width_i = 0; droplet_class_i = 0;
    sys_addr = 0; sys_wdata = 0; sys_sel = 4'hF; sys_wen = 0; sys_ren = 0;
    model_reset();
    repeat (3) @(posedge adc_clk_i);
    #1;
    checks++;
    if (sys_ack !== 1'b0) begin
      failures++; $display("FAIL reset_ack: got %b want 0", sys_ack);
    end
    checks++;
    if (sys_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h want 0", sys_rdata);
    end
    checks++;
    if (sys_err !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b want 0", sys_err);
    end
    adc_rstn_i = 1'b1;
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h2000_0000 || sys_ack !== 1'b1) begin
      failures++; $display("FAIL reset_status: got %h ack %b want 20000000 ack 1", sys_rdata, sys_ack);
    end
    bus_read(32'h4);
    checks++;
    if (sys_rdata !== 32'h1) begin
      failures++; $display("FAIL reset_ctrl: got %h want 1", sys_rdata);
    end
  endtask

  task automatic test_single();
    droplet_id_i        = 1;
    droplet_intensity_i = -14'sd5;
    droplet_width_i     = 300;
    droplet_class_i     = 8'h92;
    bus_read(32'h0);  // same edge as the capture: old count
    checks++;
    if (sys_rdata !== 32'h2000_0000) begin
      failures++; $display("FAIL single_latency: got %h want 20000000", sys_rdata);
    end
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h0000_0001) begin
      failures++; $display("FAIL single_status: got %h want 00000001", sys_rdata);
    end
    bus_read(32'h10);
    checks++;
    if (sys_rdata !== 32'd1) begin
      failures++; $display("FAIL single_w0: got %h want 1", sys_rdata);
    end
    bus_read(32'h14);
    checks++;
    if (sys_rdata !== 32'd300) begin
      failures++; $display("FAIL single_w1: got %0d want 300", sys_rdata);
    end
    bus_read(32'h18);
    checks++;
    if (sys_rdata !== 32'h9200_3FFB) begin
      failures++; $display("FAIL single_w2: got %h want 92003ffb", sys_rdata);
    end
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h2000_0000) begin
      failures++; $display("FAIL single_drained: got %h want 20000000", sys_rdata);
    end
  endtask

  task automatic test_sorter_reset();
    new_drop(7);
    new_drop(0);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h0000_0001) begin
      failures++; $display("FAIL sreset_zero_id: got %h want 00000001", sys_rdata);
    end
    new_drop(1);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h0000_0002) begin
      failures++; $display("FAIL sreset_after: got %h want 00000002", sys_rdata);
    end
    bus_read(32'h10);
    checks++;
    if (sys_rdata !== 32'd7) begin
      failures++; $display("FAIL sreset_id0: got %0d want 7", sys_rdata);
    end
    bus_read(32'h18);
    bus_read(32'h10);
    checks++;
    if (sys_rdata !== 32'd1) begin
      failures++; $display("FAIL sreset_id1: got %0d want 1", sys_rdata);
    end
    bus_read(32'h18);
  endtask

  task automatic test_fill();
    for (int i = 2; i <= 7; i++) new_drop(i);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'hC000_0004) begin
      failures++; $display("FAIL fill_status: got %h want c0000004", sys_rdata);
    end
    bus_read(32'h8);
    checks++;
    if (sys_rdata !== 32'd2) begin
      failures++; $display("FAIL fill_dropped: got %0d want 2", sys_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h10);
      checks++;
      if (sys_rdata !== 32'(2 + i)) begin
        failures++; $display("FAIL fill_drain_id: got %0d want %0d", sys_rdata, 2 + i);
      end
      bus_read(32'h18);
      checks++;
      if (sys_rdata !== exp_rdata) begin
        failures++; $display("FAIL fill_drain_w2: got %h want %h", sys_rdata, exp_rdata);
      end
    end
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'hA000_0000) begin
      failures++; $display("FAIL fill_empty: got %h want a0000000", sys_rdata);
    end
  endtask

  task automatic test_push_pop_full();
    for (int i = 10; i <= 13; i++) new_drop(i);
    droplet_id_i = 14;
    bus_read(32'h18);
    checks++;
    if (sys_rdata !== exp_rdata) begin
      failures++; $display("FAIL pp_head: got %h want %h", sys_rdata, exp_rdata);
    end
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'hC000_0004) begin
      failures++; $display("FAIL pp_status: got %h want c0000004", sys_rdata);
    end
    bus_read(32'h8);
    checks++;
    if (sys_rdata !== 32'd2) begin
      failures++; $display("FAIL pp_dropped: got %0d want 2", sys_rdata);
    end
    for (int i = 11; i <= 14; i++) begin
      bus_read(32'h10);
      checks++;
      if (sys_rdata !== 32'(i)) begin
        failures++; $display("FAIL pp_drain_id: got %0d want %0d", sys_rdata, i);
      end
      bus_read(32'h18);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] id;
    id = 100;
    for (int i = 0; i < 10; i++) begin
      id = id + 1 + $urandom_range(0, 1000);
      new_drop(id);
      for (int w = 0; w < 3; w++) begin
        bus_read(32'h10 + 32'(4 * w));
        checks++;
        if (sys_rdata !== exp_rdata || (w == 0 && sys_rdata !== id)) begin
          failures++;
          $display("FAIL wrap_w%0d: got %h want %h (id %h)", w, sys_rdata, exp_rdata, id);
        end
      end
    end
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'hA000_0000) begin
      failures++; $display("FAIL wrap_status: got %h want a0000000", sys_rdata);
    end
  endtask

  task automatic test_ctrl();
    for (int i = 0; i < 3; i++) new_drop(32'(5000 + i));
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h8000_0003) begin
      failures++; $display("FAIL ctrl_pre: got %h want 80000003", sys_rdata);
    end
    bus_write(32'h4, 32'h2);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h2000_0000) begin
      failures++; $display("FAIL ctrl_clear_status: got %h want 20000000", sys_rdata);
    end
    bus_read(32'h8);
    checks++;
    if (sys_rdata !== 32'h0) begin
      failures++; $display("FAIL ctrl_clear_dropped: got %h want 0", sys_rdata);
    end
    bus_write(32'h4, 32'h0);
    new_drop(6000);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h2000_0000) begin
      failures++; $display("FAIL ctrl_disabled: got %h want 20000000", sys_rdata);
    end
    bus_read(32'h18);
    checks++;
    if (sys_rdata !== 32'h0 || sys_ack !== 1'b1) begin
      failures++; $display("FAIL ctrl_empty_head: got %h ack %b want 0 ack 1", sys_rdata, sys_ack);
    end
    bus_write(32'h40, 32'hFFFF_FFFF);
    checks++;
    if (sys_ack !== 1'b1) begin
      failures++; $display("FAIL ctrl_other_wr_ack: got %b want 1", sys_ack);
    end
    bus_write(32'h4, 32'h1);
    // Disable in the same cycle as a new id: old enable still applies.
    droplet_id_i = 6001;
    bus_write(32'h4, 32'h0);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h0000_0001) begin
      failures++; $display("FAIL ctrl_en_timing: got %h want 00000001", sys_rdata);
    end
    bus_write(32'h4, 32'h1);
    bus_read(32'h18);
  endtask

  task automatic test_async_reset();
    new_drop(7000);
    new_drop(7001);
    bus_read(32'h0);
    #2;
    adc_rstn_i   = 1'b0;
    droplet_id_i = 0;
    #1;
    checks++;
    if (sys_ack !== 1'b0 || sys_rdata !== 32'h0) begin
      failures++; $display("FAIL areset_immediate: ack %b rdata %h want 0 0", sys_ack, sys_rdata);
    end
    model_reset();
    @(posedge adc_clk_i);
    #1;
    adc_rstn_i = 1'b1;
    new_drop(9);
    bus_read(32'h0);
    checks++;
    if (sys_rdata !== 32'h0000_0001) begin
      failures++; $display("FAIL areset_status: got %h want 00000001", sys_rdata);
    end
    bus_read(32'h10);
    checks++;
    if (sys_rdata !== 32'd9) begin
      failures++; $display("FAIL areset_id: got %0d want 9", sys_rdata);
    end
    bus_read(32'h18);
  endtask

  task automatic test_random();
    logic [31:0] addrs [7];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h3C};
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 4) begin
        droplet_id_i        = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 20));
        droplet_intensity_i = 14'($urandom);
        droplet_width_i     = $urandom;
        droplet_class_i     = 8'($urandom);
      end
      sys_ren = 1'b0;
      sys_wen = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        sys_wen   = 1'b1;
        sys_addr  = 32'h4;
        sys_wdata = {30'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0};
      end else if ($urandom_range(0, 9) < 6) begin
        sys_ren  = 1'b1;
        sys_addr = addrs[$urandom_range(0, 6)];
      end
      tick();
      checks++;
      if (sys_ack !== exp_ack || sys_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL random_cycle%0d: ack %b rdata %h want ack %b rdata %h",
                 c, sys_ack, sys_rdata, exp_ack, exp_rdata);
      end
    end
    sys_ren = 1'b0;
    sys_wen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sorter_reset();
    test_fill();
    test_push_pop_full();
    test_wrap();
    test_ctrl();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
